systolic_result_collector: RTL and testbench
============================================

Name: systolic_result_collector

Overview:
- Drain-side counterpart of the diagonal-skew delay buffers that feed the systolic array.
- Captures the staggered per-column outputs of a DIM x DIM array: column c's result for row r arrives r+c cycles after the start of the wave.
- Reassembles them into aligned rows and presents them one row per transfer on a valid/ready interface toward the CCI-P write-back path.

Parameters:
- DIM, 8, array dimension: number of columns and rows collected per wave.
- BITS, 64, width of one result element.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  asynchronous active-high reset.
- start  input  1  single-cycle pulse; the same cycle is wave cycle t=0.
- col_in  input  DIM*BITS  packed column outputs; column c occupies bits [c*BITS +: BITS].
- busy  output  1  high in COLLECT or DRAIN.
- out_data  output  DIM*BITS  one aligned row; element c at [c*BITS +: BITS].
- out_valid  output  1  out_data holds a valid row.
- out_ready  input  1  consumer accepts the row when out_valid & out_ready.
- done  output  1  one-cycle pulse after the last row is accepted.

Behaviour:
- Reset (async, rst=1): state=IDLE, wave counter=0, row pointer=0, capture buffer cleared to 0, out_data=0, out_valid=0, busy=0, done=0. Reset mid-COLLECT or mid-DRAIN abandons the wave with no partial output.
- Storage: DIM x DIM buffer buf[r][c], each BITS wide.
- IDLE:
  - start=1 -> COLLECT with t=0; column capture is performed in that same cycle.
  - start=0 -> remain in IDLE.
- COLLECT (cycles t = 0 .. 2*DIM-2):
  - For every column c with 0 <= t-c < DIM, write buf[t-c][c] <= col_in[c].
  - Column values outside that window are ignored.
  - After capture at t=2*DIM-2 -> DRAIN with row pointer=0.
  - Counter width is clog2(2*DIM-1), minimum 1 bit.
- DRAIN:
  - out_valid=1 and out_data=buf[row_ptr], both registered.
  - The first row is valid in the cycle after the final capture cycle.
  - Accept (out_valid & out_ready): row_ptr increments and the next row appears the following cycle.
  - out_data must stay stable while out_valid=1 and out_ready=0.
  - Accepting row DIM-1: out_valid=0 next cycle, done=1 for exactly that one cycle, state -> IDLE.
- Latency: start to first out_valid = 2*DIM-1 cycles. With out_ready held high, one row per cycle, so the wave completes 3*DIM-1 cycles after start.
- start while busy=1 is ignored, with no effect on the wave in progress.
- start in the same cycle as done is accepted: done and the new COLLECT t=0 coincide.
- busy=1 exactly when state is COLLECT or DRAIN.
- No arithmetic on data; elements are passed bit-exact.

Optional Feature:
- Macro: COLLECTOR_TRANSPOSE_EN.
- Defined: DRAIN emits columns instead of rows. Transfer k carries element r = buf[r][k] at [r*BITS +: BITS]. Count, timing and handshake are unchanged.
- Undefined: row order as above; no transpose logic is synthesized.

Test Plan:
- Basic wave, DIM=4, BITS=16: start at cycle 0; drive col_in[c] at cycle t = 16'h(r*16+c) for r=t-c, otherwise 16'hDEAD; out_ready=1 -> out_valid from cycle 7 to cycle 10, row r = {r*16+3, r*16+2, r*16+1, r*16+0}; done=1 at cycle 11; 16'hDEAD never appears in out_data.
- Backpressure: same wave; out_ready=0 for cycles 7-9, then toggle 1/0 every cycle -> out_data stays stable while stalled; rows 0..3 emitted in order exactly once; done after the 4th accept only.
- Ignored start: pulse start again at cycles 3 and 8 of a wave -> busy stays 1; output identical to the basic wave; no second wave begins.
- Back-to-back: assert start in the done cycle with new data (+16'h100 offset) -> second wave's rows follow with the same 2*DIM-1 latency; no data mixed between waves.
- Reset mid-operation: assert rst at cycle 5 (COLLECT), then at cycle 8 of a later wave (DRAIN) -> immediately out_valid=0, busy=0, done=0, out_data=0; the next start yields a clean wave.
- Macro defined: basic-wave stimulus -> transfer k = {3*16+k, 2*16+k, 1*16+k, 0*16+k}.

Source files
------------

// File: rtl/systolic_result_collector.sv
// rtl/systolic_result_collector.sv - reassembles skewed systolic column outputs into aligned rows
//
// Purpose: captures the diagonally staggered per-column results of a DIM x DIM
// systolic array (column c, row r arrives r+c cycles after start) and drains
// them as aligned rows over a valid/ready interface.
//
// Optional feature macro: COLLECTOR_TRANSPOSE_EN
//   defined   -> DRAIN emits columns (transfer k element r = buf[r][k])
//   undefined -> DRAIN emits rows    (transfer k element c = buf[k][c])
//
// Ports:
//   clk        clock, all state updates on posedge
//   rst        asynchronous active-high reset
//   start      single-cycle pulse, its cycle is wave cycle t=0
//   col_in     packed column outputs, column c at [c*BITS +: BITS]
//   busy       high while collecting or draining
//   out_data   one aligned transfer, element i at [i*BITS +: BITS]
//   out_valid  out_data holds a valid transfer
//   out_ready  consumer accepts when out_valid & out_ready
//   done       one-cycle pulse after the last transfer is accepted
module systolic_result_collector #(
  parameter int DIM  = 8,
  parameter int BITS = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [DIM*BITS-1:0] col_in,
  output logic                busy,
  output logic [DIM*BITS-1:0] out_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                done
);

  localparam int LAST_T = 2*DIM - 2;
  localparam int CW     = (2*DIM - 1) > 1 ? $clog2(2*DIM - 1) : 1;
  localparam int RW     = DIM > 1 ? $clog2(DIM) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DRAIN   = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [RW-1:0]        ptr_q, ptr_d;
  logic [BITS-1:0]      cap_q [DIM][DIM];
  logic [BITS-1:0]      cap_d [DIM][DIM];
  logic [DIM*BITS-1:0]  data_d;
  logic                 valid_d;
  logic                 done_d;

  logic                 capture;
  logic                 load;
  int                   t;
  int                   load_idx;

  assign busy = (state_q != IDLE);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ptr_d    = ptr_q;
    cap_d    = cap_q;
    data_d   = out_data;
    valid_d  = out_valid;
    done_d   = 1'b0;
    capture  = 1'b0;
    load     = 1'b0;
    t        = 0;
    load_idx = 0;

    case (state_q)
      IDLE: begin
        if (start) begin
          // The start cycle is itself t=0, so its column 0 value is captured now.
          capture = 1'b1;
          t       = 0;
          if (LAST_T == 0) begin
            state_d = DRAIN;
            ptr_d   = '0;
            load    = 1'b1;
          end else begin
            state_d = COLLECT;
            cnt_d   = CW'(1);
          end
        end
      end
      COLLECT: begin
        capture = 1'b1;
        t       = int'(cnt_q);
        if (t == LAST_T) begin
          state_d = DRAIN;
          cnt_d   = '0;
          ptr_d   = '0;
          load    = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DRAIN: begin
        if (out_valid && out_ready) begin
          if (int'(ptr_q) == DIM - 1) begin
            state_d = IDLE;
            ptr_d   = '0;
            valid_d = 1'b0;
            done_d  = 1'b1;
          end else begin
            ptr_d    = ptr_q + RW'(1);
            load     = 1'b1;
            load_idx = int'(ptr_q) + 1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Row r of column c is on the wire at wave cycle r+c; anything else is ignored.
    if (capture) begin
      for (int r = 0; r < DIM; r++) begin
        for (int c = 0; c < DIM; c++) begin
          if (r + c == t) begin
            cap_d[r][c] = col_in[c*BITS +: BITS];
          end
        end
      end
    end

    // Read from the post-capture buffer so the final diagonal element is
    // already visible when the first transfer is loaded.
    if (load) begin
      valid_d = 1'b1;
      for (int r = 0; r < DIM; r++) begin
        for (int c = 0; c < DIM; c++) begin
`ifdef COLLECTOR_TRANSPOSE_EN
          if (c == load_idx) begin
            data_d[r*BITS +: BITS] = cap_d[r][c];
          end
`else
          if (r == load_idx) begin
            data_d[c*BITS +: BITS] = cap_d[r][c];
          end
`endif
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      ptr_q     <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      done      <= 1'b0;
      for (int r = 0; r < DIM; r++) begin
        for (int c = 0; c < DIM; c++) begin
          cap_q[r][c] <= '0;
        end
      end
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ptr_q     <= ptr_d;
      out_data  <= data_d;
      out_valid <= valid_d;
      done      <= done_d;
      cap_q     <= cap_d;
    end
  end

endmodule

// File: tb/tb_systolic_result_collector.sv
// tb/tb_systolic_result_collector.sv - self-checking bench for systolic_result_collector
module tb_systolic_result_collector;

  localparam int DIM  = 4;
  localparam int BITS = 16;
  localparam int W    = DIM * BITS;
  localparam logic [15:0] DEAD = 16'hDEAD;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         out_ready = 1'b0;
  logic [W-1:0] col_in = '0;
  logic         busy;
  logic [W-1:0] out_data;
  logic         out_valid;
  logic         done;

  always #5 clk = ~clk;

  systolic_result_collector #(.DIM(DIM), .BITS(BITS)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .col_in    (col_in),
    .busy      (busy),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .done      (done)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0]  m [2][DIM][DIM];
  bit           rdy [128];
  bit           busy_log [128];
  logic [W-1:0] got [$];
  int           got_cyc [$];
  int           done_cyc [$];
  int           exp_cyc [$];
  int           exp_done [$];
  int           first_valid;
  int           stall_bad;
  int           dead_seen;

  // Expected transfer k of wave w, straight from the matrix the bench drove.
  function automatic logic [W-1:0] exp_xfer(input int w, input int k);
    logic [W-1:0] v;
    v = '0;
    for (int e = 0; e < DIM; e++) begin
`ifdef COLLECTOR_TRANSPOSE_EN
      v[e*BITS +: BITS] = m[w][e][k];
`else
      v[e*BITS +: BITS] = m[w][k][e];
`endif
    end
    return v;
  endfunction

  // Handshake model: first transfer offered 2*DIM-1 cycles after start,
  // one accept per ready cycle, done the cycle after the DIM-th accept.
  function automatic void model_wave(input int s);
    int n;
    int cyc;
    n   = 0;
    cyc = s + 2*DIM - 1;
    while (n < DIM && cyc < 128) begin
      if (rdy[cyc]) begin
        exp_cyc.push_back(cyc);
        n++;
      end
      cyc++;
    end
    exp_done.push_back(cyc);
  endfunction

  task automatic fill(input int w, input bit rnd, input logic [15:0] off);
    logic [15:0] v;
    for (int r = 0; r < DIM; r++) begin
      for (int c = 0; c < DIM; c++) begin
        if (rnd) begin
          v = 16'($urandom);
          if (v == DEAD) v = 16'h0;
        end else begin
          v = off + 16'(r*16 + c);
        end
        m[w][r][c] = v;
      end
    end
  endtask

  task automatic set_inputs(input int t, input int w);
    int r;
    for (int c = 0; c < DIM; c++) begin
      r = t - c;
      col_in[c*BITS +: BITS] = (r >= 0 && r < DIM) ? m[w][r][c] : DEAD;
    end
  endtask

  task automatic ready_all(input bit v);
    for (int i = 0; i < 128; i++) rdy[i] = v;
    exp_cyc.delete();
    exp_done.delete();
  endtask

  task automatic run_wave(input int ncyc, input int ign_a, input int ign_b, input int b2b);
    bit           pv;
    bit           pr;
    logic [W-1:0] pd;
    pv = 1'b0;
    pr = 1'b0;
    pd = '0;
    got.delete();
    got_cyc.delete();
    done_cyc.delete();
    first_valid = -1;
    stall_bad   = 0;
    dead_seen   = 0;
    for (int cyc = 0; cyc < ncyc; cyc++) begin
      @(negedge clk);
      busy_log[cyc] = busy;
      if (done) done_cyc.push_back(cyc);
      if (out_valid) begin
        if (first_valid < 0) first_valid = cyc;
        for (int c = 0; c < DIM; c++)
          if (out_data[c*BITS +: BITS] == DEAD) dead_seen++;
      end
      if (pv && !pr && (!out_valid || out_data !== pd)) stall_bad++;
      start = (cyc == 0) || (cyc == ign_a) || (cyc == ign_b) || (cyc == b2b);
      if (b2b >= 0 && cyc >= b2b) set_inputs(cyc - b2b, 1);
      else set_inputs(cyc, 0);
      out_ready = rdy[cyc];
      if (out_valid && out_ready) begin
        got.push_back(out_data);
        got_cyc.push_back(cyc);
      end
      pv = out_valid;
      pr = out_ready;
      pd = out_data;
    end
    @(negedge clk);
    start     = 1'b0;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b want=0", busy); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b want=0", out_valid); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b want=0", done); end
    n_checks++; if (out_data !== '0) begin n_fail++; $display("FAIL reset_data got=%h want=0", out_data); end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL idle_busy got=%b want=0", busy); end
  endtask

  task automatic test_basic();
    int           bad;
    bit           eb;
    logic [W-1:0] lit;
    fill(0, 1'b0, 16'h0);
    ready_all(1'b1);
    model_wave(0);
    run_wave(16, -1, -1, -1);
    n_checks++; if (got.size() != DIM) begin n_fail++; $display("FAIL basic_count got=%0d want=%0d", got.size(), DIM); end
    for (int i = 0; i < DIM; i++) begin
      n_checks++;
      if (i >= got.size() || got[i] !== exp_xfer(0, i) || got_cyc[i] != exp_cyc[i]) begin
        n_fail++;
        $display("FAIL basic_row%0d got=%h@%0d want=%h@%0d", i, (i < got.size()) ? got[i] : 'x,
                 (i < got.size()) ? got_cyc[i] : -1, exp_xfer(0, i), exp_cyc[i]);
      end
    end
`ifdef COLLECTOR_TRANSPOSE_EN
    lit = 64'h0030_0020_0010_0000;
`else
    lit = 64'h0003_0002_0001_0000;
`endif
    if (got.size() > 0) begin
      n_checks++; if (got[0] !== lit) begin n_fail++; $display("FAIL basic_first_lit got=%h want=%h", got[0], lit); end
    end
    n_checks++; if (first_valid != 2*DIM - 1) begin n_fail++; $display("FAIL basic_latency got=%0d want=%0d", first_valid, 2*DIM - 1); end
    n_checks++;
    if (done_cyc.size() != 1 || done_cyc[0] != 3*DIM - 1) begin
      n_fail++;
      $display("FAIL basic_done got=%0d pulses first@%0d want=1@%0d", done_cyc.size(),
               (done_cyc.size() > 0) ? done_cyc[0] : -1, 3*DIM - 1);
    end
    n_checks++; if (dead_seen != 0) begin n_fail++; $display("FAIL basic_dead got=%0d want=0", dead_seen); end
    bad = 0;
    for (int c = 0; c < 16; c++) begin
      eb = (c > 0) && (c < exp_done[0]);
      if (busy_log[c] != eb) bad++;
    end
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL basic_busy got=%0d bad cycles want=0", bad); end
  endtask

  task automatic test_backpressure();
    fill(0, 1'b0, 16'h0);
    ready_all(1'b1);
    for (int i = 7; i <= 9; i++) rdy[i] = 1'b0;
    for (int i = 10; i < 128; i++) rdy[i] = ((i - 10) % 2 == 0);
    model_wave(0);
    run_wave(24, -1, -1, -1);
    n_checks++; if (got.size() != DIM) begin n_fail++; $display("FAIL bp_count got=%0d want=%0d", got.size(), DIM); end
    for (int i = 0; i < DIM; i++) begin
      n_checks++;
      if (i >= got.size() || got[i] !== exp_xfer(0, i) || got_cyc[i] != exp_cyc[i]) begin
        n_fail++;
        $display("FAIL bp_row%0d got=%h@%0d want=%h@%0d", i, (i < got.size()) ? got[i] : 'x,
                 (i < got.size()) ? got_cyc[i] : -1, exp_xfer(0, i), exp_cyc[i]);
      end
    end
    n_checks++; if (stall_bad != 0) begin n_fail++; $display("FAIL bp_stable got=%0d changes want=0", stall_bad); end
    n_checks++;
    if (done_cyc.size() != 1 || done_cyc[0] != exp_done[0]) begin
      n_fail++;
      $display("FAIL bp_done got=%0d pulses first@%0d want=1@%0d", done_cyc.size(),
               (done_cyc.size() > 0) ? done_cyc[0] : -1, exp_done[0]);
    end
  endtask

  task automatic test_ignored_start();
    int bad;
    fill(0, 1'b0, 16'h0);
    ready_all(1'b1);
    model_wave(0);
    run_wave(30, 3, 8, -1);
    n_checks++; if (got.size() != DIM) begin n_fail++; $display("FAIL ign_count got=%0d want=%0d", got.size(), DIM); end
    for (int i = 0; i < DIM; i++) begin
      n_checks++;
      if (i >= got.size() || got[i] !== exp_xfer(0, i) || got_cyc[i] != exp_cyc[i]) begin
        n_fail++;
        $display("FAIL ign_row%0d got=%h want=%h", i, (i < got.size()) ? got[i] : 'x, exp_xfer(0, i));
      end
    end
    bad = 0;
    for (int c = 0; c < 30; c++)
      if (busy_log[c] != ((c > 0) && (c < exp_done[0]))) bad++;
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL ign_busy got=%0d bad cycles want=0", bad); end
    n_checks++; if (done_cyc.size() != 1) begin n_fail++; $display("FAIL ign_done got=%0d pulses want=1", done_cyc.size()); end
  endtask

  task automatic test_back_to_back();
    int b2b;
    int bad;
    bit eb;
    b2b = 3*DIM - 1;
    fill(0, 1'b0, 16'h0);
    fill(1, 1'b0, 16'h100);
    ready_all(1'b1);
    model_wave(0);
    model_wave(b2b);
    run_wave(28, -1, -1, b2b);
    n_checks++; if (got.size() != 2*DIM) begin n_fail++; $display("FAIL b2b_count got=%0d want=%0d", got.size(), 2*DIM); end
    for (int i = 0; i < 2*DIM; i++) begin
      n_checks++;
      if (i >= got.size() || got[i] !== exp_xfer(i / DIM, i % DIM) || got_cyc[i] != exp_cyc[i]) begin
        n_fail++;
        $display("FAIL b2b_xfer%0d got=%h@%0d want=%h@%0d", i, (i < got.size()) ? got[i] : 'x,
                 (i < got.size()) ? got_cyc[i] : -1, exp_xfer(i / DIM, i % DIM), exp_cyc[i]);
      end
    end
    n_checks++;
    if (done_cyc.size() != 2 || done_cyc[0] != exp_done[0] || done_cyc[1] != exp_done[1]) begin
      n_fail++;
      $display("FAIL b2b_done got=%0d pulses want=2 at %0d,%0d", done_cyc.size(), exp_done[0], exp_done[1]);
    end
    bad = 0;
    for (int c = 0; c < 28; c++) begin
      eb = ((c > 0) && (c < exp_done[0])) || ((c > b2b) && (c < exp_done[1]));
      if (busy_log[c] != eb) bad++;
    end
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL b2b_busy got=%0d bad cycles want=0", bad); end
  endtask

  task automatic test_random();
    for (int it = 0; it < 3; it++) begin
      fill(0, 1'b1, 16'h0);
      ready_all(1'b1);
      for (int i = 0; i < 50; i++) rdy[i] = 1'($urandom_range(0, 1));
      model_wave(0);
      run_wave(70, -1, -1, -1);
      n_checks++; if (got.size() != DIM) begin n_fail++; $display("FAIL rnd%0d_count got=%0d want=%0d", it, got.size(), DIM); end
      for (int i = 0; i < DIM; i++) begin
        n_checks++;
        if (i >= got.size() || got[i] !== exp_xfer(0, i) || got_cyc[i] != exp_cyc[i]) begin
          n_fail++;
          $display("FAIL rnd%0d_xfer%0d got=%h@%0d want=%h@%0d", it, i, (i < got.size()) ? got[i] : 'x,
                   (i < got.size()) ? got_cyc[i] : -1, exp_xfer(0, i), exp_cyc[i]);
        end
      end
      n_checks++; if (stall_bad != 0) begin n_fail++; $display("FAIL rnd%0d_stable got=%0d want=0", it, stall_bad); end
      n_checks++;
      if (done_cyc.size() != 1 || done_cyc[0] != exp_done[0]) begin
        n_fail++;
        $display("FAIL rnd%0d_done got=%0d pulses want=1@%0d", it, done_cyc.size(), exp_done[0]);
      end
    end
  endtask

  task automatic test_reset_mid();
    for (int phase = 0; phase < 2; phase++) begin
      fill(0, 1'b1, 16'h0);
      for (int cyc = 0; cyc < ((phase == 0) ? 5 : 8); cyc++) begin
        @(negedge clk);
        start = (cyc == 0);
        set_inputs(cyc, 0);
        out_ready = (cyc < 7);
      end
      @(negedge clk);
      start = 1'b0;
      n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rmid%0d_pre_busy got=%b want=1", phase, busy); end
      if (phase == 1) begin
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== exp_xfer(0, 0)) begin
          n_fail++;
          $display("FAIL rmid_pre_drain got=%b/%h want=1/%h", out_valid, out_data, exp_xfer(0, 0));
        end
      end
      rst = 1'b1;
      #1;
      n_checks++;
      if (busy !== 1'b0 || out_valid !== 1'b0 || done !== 1'b0 || out_data !== '0) begin
        n_fail++;
        $display("FAIL rmid%0d_clear got=busy%b valid%b done%b data%h want=all 0", phase, busy, out_valid, done, out_data);
      end
      @(negedge clk);
      rst = 1'b0;
      fill(0, 1'b1, 16'h0);
      ready_all(1'b1);
      model_wave(0);
      run_wave(16, -1, -1, -1);
      for (int i = 0; i < DIM; i++) begin
        n_checks++;
        if (i >= got.size() || got[i] !== exp_xfer(0, i) || got_cyc[i] != exp_cyc[i]) begin
          n_fail++;
          $display("FAIL rmid%0d_clean%0d got=%h want=%h", phase, i, (i < got.size()) ? got[i] : 'x, exp_xfer(0, i));
        end
      end
      n_checks++;
      if (done_cyc.size() != 1 || done_cyc[0] != exp_done[0]) begin
        n_fail++;
        $display("FAIL rmid%0d_done got=%0d pulses want=1@%0d", phase, done_cyc.size(), exp_done[0]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_ignored_start();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
